// File: rtl/eth_switch_2port.sv
// Two-port 32-bit packet switch: per-input FIFOs with SOP/EOP framing, DA-based
// routing, unknown-DA discard and per-output round-robin whole-packet arbitration.
package eth_switch_2port_pkg;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } fifoWord_t;
endpackage

module eth_switch_2port
  import eth_switch_2port_pkg::*;
#(
  parameter logic [DATA_W-1:0] PORTA_ADDR    = 32'h0000_ABCD,
  parameter logic [DATA_W-1:0] PORTB_ADDR    = 32'h0000_BEEF,
  parameter int unsigned       FIFO_DEPTH    = 64,
  parameter int unsigned       MAX_PKT_WORDS = 32
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [DATA_W-1:0] inDataA,
  input  logic              inSopA,
  input  logic              inEopA,
  input  logic [DATA_W-1:0] inDataB,
  input  logic              inSopB,
  input  logic              inEopB,
  output logic [DATA_W-1:0] outDataA,
  output logic              outSopA,
  output logic              outEopA,
  output logic [DATA_W-1:0] outDataB,
  output logic              outSopB,
  output logic              outEopB,
  output logic              portAStall,
  output logic              portBStall
);
  localparam int unsigned NPORT     = 2;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned STALL_LVL = FIFO_DEPTH - MAX_PKT_WORDS - 2;

  typedef enum logic [1:0] {ARB_IDLE, ARB_FROM_A, ARB_FROM_B} arbState_t;
  typedef enum logic {DROP_IDLE, DROP_BUSY} dropState_t;

  fifoWord_t        inWord    [NPORT];
  fifoWord_t        fifoMem   [NPORT][FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr     [NPORT];
  logic [PTR_W-1:0] rdPtr     [NPORT];
  logic [CNT_W-1:0] count     [NPORT];
  logic             inPkt     [NPORT];
  logic             push      [NPORT];
  logic             pop       [NPORT];
  fifoWord_t        head      [NPORT];
  logic             headVld   [NPORT];
  logic             headSop   [NPORT];
  logic             wantA     [NPORT];
  logic             wantB     [NPORT];
  logic             badDa     [NPORT];
  logic             reqFromA  [NPORT];
  logic             reqFromB  [NPORT];
  logic             dropPop   [NPORT];
  dropState_t       dropState [NPORT];
  dropState_t       dropNext  [NPORT];
  arbState_t        arbState  [NPORT];
  arbState_t        arbNext   [NPORT];
  logic             prefB     [NPORT];
  logic             prefBNext [NPORT];
  logic             fwdVld    [NPORT];
  logic             fwdSrc    [NPORT];
  fifoWord_t        outWord   [NPORT];

  always_comb begin
    inWord[0] = '{sop: inSopA, eop: inEopA, data: inDataA};
    inWord[1] = '{sop: inSopB, eop: inEopB, data: inDataB};
  end

  // Input framing and head-of-FIFO route decode.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      push[p]    = (inWord[p].sop || inPkt[p]) && (count[p] != CNT_W'(FIFO_DEPTH));
      head[p]    = fifoMem[p][rdPtr[p]];
      headVld[p] = (count[p] != '0);
      headSop[p] = headVld[p] && head[p].sop;
      wantA[p]   = headSop[p] && (head[p].data == PORTA_ADDR);
      wantB[p]   = headSop[p] && (head[p].data == PORTB_ADDR);
      badDa[p]   = headSop[p] && !wantA[p] && !wantB[p];
    end
    reqFromA[0] = wantA[0];
    reqFromB[0] = wantA[1];
    reqFromA[1] = wantB[0];
    reqFromB[1] = wantB[1];
  end

  // Per-output arbiter; priority only flips when both inputs actually contend.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      arbNext[o]   = arbState[o];
      prefBNext[o] = prefB[o];
      fwdVld[o]    = 1'b0;
      fwdSrc[o]    = 1'b0;
    end
    for (int o = 0; o < NPORT; o++) begin
      unique case (arbState[o])
        ARB_IDLE: begin
          if (reqFromA[o] && !(reqFromB[o] && prefB[o])) begin
            fwdVld[o]  = 1'b1;
            fwdSrc[o]  = 1'b0;
            arbNext[o] = ARB_FROM_A;
          end else if (reqFromB[o]) begin
            fwdVld[o]  = 1'b1;
            fwdSrc[o]  = 1'b1;
            arbNext[o] = ARB_FROM_B;
          end
          if (reqFromA[o] && reqFromB[o]) prefBNext[o] = !prefB[o];
        end
        ARB_FROM_A, ARB_FROM_B: begin
          fwdSrc[o] = (arbState[o] == ARB_FROM_B);
          // A fresh SOP at the head means the sender cut the packet short.
          if (headSop[fwdSrc[o]]) begin
            arbNext[o] = ARB_IDLE;
          end else if (headVld[fwdSrc[o]]) begin
            fwdVld[o] = 1'b1;
            if (head[fwdSrc[o]].eop) arbNext[o] = ARB_IDLE;
          end
        end
        default: arbNext[o] = ARB_IDLE;
      endcase
    end
  end

  // Unknown-DA discard, one word per cycle through EOP.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      dropNext[p] = dropState[p];
      dropPop[p]  = 1'b0;
      case (dropState[p])
        DROP_IDLE: begin
          if (badDa[p]) begin
            dropPop[p] = 1'b1;
            if (!head[p].eop) dropNext[p] = DROP_BUSY;
          end
        end
        DROP_BUSY: begin
          if (headSop[p]) begin
            dropNext[p] = DROP_IDLE;
          end else if (headVld[p]) begin
            dropPop[p] = 1'b1;
            if (head[p].eop) dropNext[p] = DROP_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      pop[p] = dropPop[p]
            || (fwdVld[0] && (fwdSrc[0] == 1'(p)))
            || (fwdVld[1] && (fwdSrc[1] == 1'(p)));
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int p = 0; p < NPORT; p++) begin
        wrPtr[p]     <= '0;
        rdPtr[p]     <= '0;
        count[p]     <= '0;
        inPkt[p]     <= 1'b0;
        dropState[p] <= DROP_IDLE;
        arbState[p]  <= ARB_IDLE;
        prefB[p]     <= 1'b0;
        outWord[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (push[p]) wrPtr[p] <= wrPtr[p] + PTR_W'(1);
        if (pop[p])  rdPtr[p] <= rdPtr[p] + PTR_W'(1);
        if (push[p] && !pop[p])      count[p] <= count[p] + CNT_W'(1);
        else if (!push[p] && pop[p]) count[p] <= count[p] - CNT_W'(1);
        if (inWord[p].sop)      inPkt[p] <= 1'b1;
        else if (inWord[p].eop) inPkt[p] <= 1'b0;
        dropState[p] <= dropNext[p];
        arbState[p]  <= arbNext[p];
        prefB[p]     <= prefBNext[p];
        outWord[p]   <= fwdVld[p] ? head[fwdSrc[p]] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (push[p]) fifoMem[p][wrPtr[p]] <= inWord[p];
    end
  end

  assign outDataA   = outWord[0].data;
  assign outSopA    = outWord[0].sop;
  assign outEopA    = outWord[0].eop;
  assign outDataB   = outWord[1].data;
  assign outSopB    = outWord[1].sop;
  assign outEopB    = outWord[1].eop;
  assign portAStall = (count[0] >= CNT_W'(STALL_LVL));
  assign portBStall = (count[1] >= CNT_W'(STALL_LVL));

endmodule

// File: tb/tb_eth_switch_2port.sv
// Randomized bench for eth_switch_2port against a queue-based packet-switch model
// evaluated once per clock edge.
module tb_eth_switch_2port;
  localparam int          FIFO_DEPTH = 64;
  localparam int          MAX_PKT    = 32;
  localparam int          STALL_LVL  = FIFO_DEPTH - MAX_PKT - 2;
  localparam logic [31:0] ADDR_A     = 32'h0000_ABCD;
  localparam logic [31:0] ADDR_B     = 32'h0000_BEEF;

  typedef logic [33:0] word_t;  // {sop, eop, data}

  logic        clk;
  logic        resetN;
  logic [31:0] inDataA, inDataB, outDataA, outDataB;
  logic        inSopA, inEopA, inSopB, inEopB;
  logic        outSopA, outEopA, outSopB, outEopB;
  logic        portAStall, portBStall;

  eth_switch_2port dut (
    .clk(clk), .resetN(resetN),
    .inDataA(inDataA), .inSopA(inSopA), .inEopA(inEopA),
    .inDataB(inDataB), .inSopB(inSopB), .inEopB(inEopB),
    .outDataA(outDataA), .outSopA(outSopA), .outEopA(outEopA),
    .outDataB(outDataB), .outSopB(outSopB), .outEopB(outEopB),
    .portAStall(portAStall), .portBStall(portBStall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: FIFOs as queues, owner of each output, fairness flag.
  word_t fqA[$], fqB[$];
  word_t pendA[$], pendB[$];
  bit    inPktM   [2];
  int    owner    [2];
  bit    prefB    [2];
  bit    dropping [2];
  word_t expOut   [2];
  bit    midPkt   [2];
  int    gap      [2];
  int    expPkts  [2];
  int    obsPkts  [2];
  int    gapMax;
  bit    randomIn;
  bit    sawStallB;
  int    errors, checks, cyc;

  function automatic int qsize(input int p);
    return (p == 0) ? fqA.size() : fqB.size();
  endfunction

  function automatic word_t qhead(input int p);
    return (p == 0) ? fqA[0] : fqB[0];
  endfunction

  function automatic void qpop(input int p);
    if (p == 0) void'(fqA.pop_front());
    else        void'(fqB.pop_front());
  endfunction

  function automatic void qpush(input int p, input word_t w);
    if (p == 0) fqA.push_back(w);
    else        fqB.push_back(w);
  endfunction

  function automatic int psize(input int p);
    return (p == 0) ? pendA.size() : pendB.size();
  endfunction

  function automatic word_t ppop(input int p);
    if (p == 0) return pendA.pop_front();
    return pendB.pop_front();
  endfunction

  function automatic void ppush(input int p, input word_t w);
    if (p == 0) pendA.push_back(w);
    else        pendB.push_back(w);
  endfunction

  function automatic word_t inWordOf(input int p);
    return (p == 0) ? {inSopA, inEopA, inDataA} : {inSopB, inEopB, inDataB};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    fqA.delete();
    fqB.delete();
    for (int p = 0; p < 2; p++) begin
      inPktM[p]   = 1'b0;
      owner[p]    = -1;
      prefB[p]    = 1'b0;
      dropping[p] = 1'b0;
      expOut[p]   = '0;
    end
  endfunction

  // One clock edge of the switch, decided on the heads as they were before the edge.
  function automatic void model_step();
    word_t       h      [2];
    bit          hv     [2];
    bit          full   [2];
    bit          popReq [2];
    bit          want   [2];
    int          pick;
    int          s;
    word_t       w;
    logic [31:0] oaddr;
    if (!resetN) begin
      model_reset();
      return;
    end
    for (int p = 0; p < 2; p++) begin
      hv[p]     = (qsize(p) != 0);
      h[p]      = hv[p] ? qhead(p) : '0;
      full[p]   = (qsize(p) >= FIFO_DEPTH);
      popReq[p] = 1'b0;
    end
    for (int o = 0; o < 2; o++) begin
      oaddr     = (o == 0) ? ADDR_A : ADDR_B;
      expOut[o] = '0;
      if (owner[o] < 0) begin
        for (int p = 0; p < 2; p++) want[p] = hv[p] && h[p][33] && (h[p][31:0] == oaddr);
        pick = -1;
        if (want[0] && want[1]) begin
          pick     = prefB[o] ? 1 : 0;
          prefB[o] = (pick == 0);
        end else if (want[0]) pick = 0;
        else if (want[1])     pick = 1;
        if (pick >= 0) begin
          expOut[o]    = h[pick];
          popReq[pick] = 1'b1;
          owner[o]     = pick;
        end
      end else begin
        s = owner[o];
        if (hv[s] && h[s][33]) owner[o] = -1;
        else if (hv[s]) begin
          expOut[o] = h[s];
          popReq[s] = 1'b1;
          if (h[s][32]) owner[o] = -1;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (dropping[p]) begin
        if (hv[p]) begin
          if (h[p][33]) dropping[p] = 1'b0;
          else begin
            popReq[p] = 1'b1;
            if (h[p][32]) dropping[p] = 1'b0;
          end
        end
      end else if (hv[p] && h[p][33] && h[p][31:0] != ADDR_A && h[p][31:0] != ADDR_B) begin
        popReq[p]   = 1'b1;
        dropping[p] = !h[p][32];
      end
    end
    for (int p = 0; p < 2; p++) if (popReq[p]) qpop(p);
    for (int p = 0; p < 2; p++) begin
      w = inWordOf(p);
      if ((w[33] || inPktM[p]) && !full[p]) qpush(p, w);
      if (w[33])      inPktM[p] = 1'b1;
      else if (w[32]) inPktM[p] = 1'b0;
    end
  endfunction

  task automatic drive_inputs();
    word_t w [2];
    bit    stall;
    for (int p = 0; p < 2; p++) begin
      stall = (p == 0) ? portAStall : portBStall;
      if (randomIn) begin
        w[p] = {2'($urandom_range(0, 3)), 32'($urandom())};
      end else if (midPkt[p]) begin
        w[p]      = ppop(p);
        midPkt[p] = !w[p][32];
        if (w[p][32]) gap[p] = int'($urandom_range(0, gapMax));
      end else if (psize(p) != 0 && gap[p] == 0 && !stall) begin
        w[p]      = ppop(p);
        midPkt[p] = 1'b1;
      end else begin
        if (gap[p] > 0) gap[p]--;
        w[p] = {1'b0, 1'($urandom_range(0, 1)), 32'($urandom())};
      end
    end
    {inSopA, inEopA, inDataA} = w[0];
    {inSopB, inEopB, inDataB} = w[1];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check("outA", 64'({outSopA, outEopA, outDataA}), 64'(expOut[0]));
    check("outB", 64'({outSopB, outEopB, outDataB}), 64'(expOut[1]));
    check("stallA", 64'(portAStall), 64'(qsize(0) >= STALL_LVL));
    check("stallB", 64'(portBStall), 64'(qsize(1) >= STALL_LVL));
    if (outSopA) obsPkts[0]++;
    if (outSopB) obsPkts[1]++;
    if (portBStall) sawStallB = 1'b1;
    drive_inputs();
  endtask

  task automatic add_pkt(input int p, input logic [31:0] da, input int len, input logic [31:0] base);
    logic [31:0] d;
    ppush(p, {2'b10, da});
    for (int i = 1; i < len; i++) begin
      d = (i == 1) ? 32'h0000_1111 : base + 32'(i - 2);
      ppush(p, {1'b0, (i == len - 1), d});
    end
    if (da == ADDR_A)      expPkts[0]++;
    else if (da == ADDR_B) expPkts[1]++;
  endtask

  function automatic logic [31:0] rand_da();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4) return ADDR_A;
    if (r < 8) return ADDR_B;
    return 32'hDEAD_0000 | 32'($urandom_range(0, 255));
  endfunction

  task automatic drain(input int budget);
    int n;
    bit busy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      busy = (psize(0) != 0) || (psize(1) != 0) || midPkt[0] || midPkt[1]
          || (qsize(0) != 0) || (qsize(1) != 0) || (owner[0] >= 0) || (owner[1] >= 0);
      if (busy) begin
        tick();
        n++;
      end
    end
    check("drain_done", 64'(busy), 64'(0));
    repeat (3) tick();
  endtask

  task automatic hold_reset(input int n);
    resetN   = 1'b0;
    randomIn = 1'b1;
    pendA.delete();
    pendB.delete();
    for (int p = 0; p < 2; p++) begin
      midPkt[p] = 1'b0;
      gap[p]    = 0;
    end
    repeat (n) tick();
    randomIn = 1'b0;
    inSopA   = 1'b0;
    inSopB   = 1'b0;
    resetN   = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    gapMax = 0; sawStallB = 1'b0;
    {inSopA, inEopA, inDataA} = '0;
    {inSopB, inEopB, inDataB} = '0;
    resetN = 1'b0;
    model_reset();
    for (int p = 0; p < 2; p++) begin
      expPkts[p] = 0; obsPkts[p] = 0; midPkt[p] = 1'b0; gap[p] = 0;
    end

    hold_reset(5);

    // Loopback packet then a packet to B, payload 1..4.
    add_pkt(0, ADDR_A, 6, 32'h1);
    add_pkt(0, ADDR_B, 6, 32'h1);
    drain(200);

    // Cross traffic in the same cycle.
    add_pkt(0, ADDR_B, 8, 32'hA000);
    add_pkt(1, ADDR_A, 8, 32'hB000);
    drain(200);

    // Contention twice on output A.
    repeat (2) begin
      add_pkt(0, ADDR_A, 4, 32'hC000);
      add_pkt(1, ADDR_A, 4, 32'hD000);
      drain(200);
    end

    // Unknown DA followed by a good packet.
    add_pkt(0, 32'h1234_5678, 5, 32'hE000);
    add_pkt(0, ADDR_A, 5, 32'hE100);
    drain(200);

    // Backpressure: B's long packets compete with A's stream for output A.
    sawStallB = 1'b0;
    for (int i = 0; i < 6; i++) add_pkt(1, ADDR_A, MAX_PKT, 32'h100 * 32'(i));
    for (int i = 0; i < 10; i++) add_pkt(0, ADDR_A, int'($urandom_range(2, MAX_PKT)), 32'h9000 + 32'(i * 64));
    drain(2000);
    check("bp_stall_seen", 64'(sawStallB), 64'(1));

    // Random mixed traffic with gaps.
    gapMax = 3;
    for (int i = 0; i < 25; i++) begin
      add_pkt(0, rand_da(), int'($urandom_range(2, MAX_PKT)), 32'($urandom()));
      add_pkt(1, rand_da(), int'($urandom_range(2, MAX_PKT)), 32'($urandom()));
    end
    drain(4000);
    check("pkts_outA", 64'(obsPkts[0]), 64'(expPkts[0]));
    check("pkts_outB", 64'(obsPkts[1]), 64'(expPkts[1]));

    // Reset in the middle of traffic, stray words, then fresh contention on B.
    gapMax = 0;
    for (int i = 0; i < 3; i++) begin
      add_pkt(0, ADDR_B, 20, 32'h5000);
      add_pkt(1, ADDR_A, 20, 32'h6000);
    end
    repeat (15) tick();
    hold_reset(3);
    for (int p = 0; p < 2; p++) begin
      expPkts[p] = 0; obsPkts[p] = 0;
    end
    repeat (4) tick();
    add_pkt(0, ADDR_B, 5, 32'h7000);
    add_pkt(1, ADDR_B, 5, 32'h8000);
    drain(200);
    check("post_reset_outA", 64'(obsPkts[0]), 64'(0));
    check("post_reset_outB", 64'(obsPkts[1]), 64'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
